// File: rtl/data_mem_loader.sv
// data_mem_loader
// Boot-time loader that sits between the host byte link (UART/JTAG bridge)
// and the data-memory write port plus the core start input. It packs byte
// pairs (low byte first) into reg_width-bit words, writes them to addresses
// 0..word_count-1, then pulses core_start once.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   load_req    start a load; only honoured in IDLE or DONE
//   byte_in     stream byte
//   byte_valid  byte_in valid
//   byte_ready  loader accepts byte_in this cycle
//   mem_addr    data-memory write address (holds between writes)
//   mem_data    data-memory write data (holds between writes)
//   mem_wren    data-memory write enable, one cycle per word
//   core_start  one-cycle start pulse to the core
//   busy        load in progress
//   done        load finished; held until next load_req or reset
//   err         sticky format/checksum error; cleared by reset or load_req
//
// Optional feature: define LOADER_CHECKSUM_EN to require two trailing
// checksum bytes (modular sum of all words) before core_start is issued.
// A mismatch sets err and skips core_start.

module data_mem_loader #(
  parameter int reg_width  = 12,
  parameter int addr_width = 12,
  parameter int word_count = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [addr_width-1:0] mem_addr,
  output logic [reg_width-1:0]  mem_data,
  output logic                  mem_wren,
  output logic                  core_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Bits of the upper word field carried by the high byte.
  localparam int HiWidth = reg_width - 8;
  localparam logic [addr_width-1:0] LastAddr = addr_width'(word_count - 1);
  localparam logic [addr_width-1:0] AddrOne  = addr_width'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StWrite,
    StStart,
    StDone
`ifdef LOADER_CHECKSUM_EN
    ,
    StCsumLow,
    StCsumHigh
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [7:0]            dataLow_q, dataLow_d;
  logic [addr_width-1:0] memAddr_q, memAddr_d;
  logic [reg_width-1:0]  memData_q, memData_d;
  logic                  memWren_q, memWren_d;
  logic                  err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [reg_width-1:0]  sum_q, sum_d;
`endif

  logic                  handshake;
  logic [reg_width-1:0]  packedWord;
  logic                  upperNonZero;

  // Word formed by the current high byte and the latched low byte; any set
  // bit of the high byte that does not fit into the word is a format error.
  assign packedWord   = {byte_in[HiWidth-1:0], dataLow_q};
  assign upperNonZero = |(byte_in >> HiWidth);
  assign handshake    = byte_valid & byte_ready;

  // Status and strobe outputs are plain decodes of the registered state,
  // so they are glitch-free and all zero while the FSM sits in IDLE.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    core_start = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StLow, StHigh: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StWrite: busy = 1'b1;
      StStart: begin
        busy       = 1'b1;
        core_start = 1'b1;
      end
      StDone: done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StCsumLow, StCsumHigh: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // The write port is registered at the high-byte handshake so that
  // mem_wren lines up with the WRITE state while mem_addr/mem_data keep
  // their last written value afterwards, independent of later low bytes.
  assign mem_addr = memAddr_q;
  assign mem_data = memData_q;
  assign mem_wren = memWren_q;
  assign err      = err_q;

  // Next-state logic: byte collection, address sequencing and error capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dataLow_d = dataLow_q;
    memAddr_d = memAddr_q;
    memData_d = memData_q;
    memWren_d = 1'b0;
    err_d     = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (load_req) begin
          state_d = StLow;
          addr_d  = '0;
          err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLow: begin
        if (handshake) begin
          dataLow_d = byte_in;
          state_d   = StHigh;
        end
      end
      StHigh: begin
        if (handshake) begin
          memWren_d = 1'b1;
          memAddr_d = addr_q;
          memData_d = packedWord;
          if (upperNonZero) err_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = sum_q + packedWord;
`endif
          state_d   = StWrite;
        end
      end
      StWrite: begin
        // The counter stops on the last address, so a full 2**addr_width
        // load never wraps back to 0.
        if (addr_q == LastAddr) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCsumLow;
`else
          state_d = StStart;
`endif
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StLow;
        end
      end
      StStart: state_d = StDone;
`ifdef LOADER_CHECKSUM_EN
      StCsumLow: begin
        if (handshake) begin
          dataLow_d = byte_in;
          state_d   = StCsumHigh;
        end
      end
      StCsumHigh: begin
        if (handshake) begin
          if (upperNonZero) err_d = 1'b1;
          if (packedWord == sum_q) begin
            state_d = StStart;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      dataLow_q <= '0;
      memAddr_q <= '0;
      memData_q <= '0;
      memWren_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dataLow_q <= dataLow_d;
      memAddr_q <= memAddr_d;
      memData_q <= memData_d;
      memWren_q <= memWren_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule
